spike_collector: RTL and testbench
==================================

Name: spike_collector

Overview:
- Output-side counterpart of the array dataflow controller. Consumes the controller's EN/FT window strobes and the array's per-timestep spike vector.
- Accumulates per-neuron spike counts over the T+1 timesteps of each output pixel.
- Packs each finished pixel's counts into IO_WIDTH-bit words and buffers them in a small FIFO drained by a valid/ready output port.

Parameters:
- N_OUT, 4, output neurons per pixel (SPK width).
- CNT_WIDTH, 8, per-neuron saturating count width.
- T_WIDTH, 5, width of T (T = timesteps-1).
- IO_WIDTH, 16, output word width. Must be a multiple of CNT_WIDTH; N_OUT*CNT_WIDTH must be a multiple of IO_WIDTH.
- DEPTH, 8, FIFO depth in words. Power of 2, >= WORDS.
- Derived: WORDS = N_OUT*CNT_WIDTH/IO_WIDTH (default 2); PER = IO_WIDTH/CNT_WIDTH (default 2).

Ports:
- CLK  in  1  clock
- RSTB  in  1  reset, asynchronous, active-low
- EN  in  1  array output valid this cycle (window strobe from dataflow controller)
- FT  in  1  first timestep of a pixel; qualified by EN
- SPK  in  N_OUT  spike vector; bit i = neuron i fired; qualified by EN
- T  in  T_WIDTH  timesteps-1; static while BUSY
- CLR  in  1  synchronous flush
- OUT_DATA  out  IO_WIDTH  FIFO head word
- OUT_VALID  out  1  FIFO non-empty
- OUT_READY  in  1  consumer accepts word
- BUSY  out  1  accumulation in progress or FIFO non-empty
- OVF  out  1  sticky: a pixel was dropped

Behaviour:
- Reset (RSTB low, async): all counts 0, t_cnt 0, state IDLE, FIFO empty, OUT_VALID 0, OUT_DATA 0, BUSY 0, OVF 0.
- Accumulator FSM, states IDLE and RUN:
  - EN&&FT, in either state: cnt[i] <= SPK[i] (zero-extended), t_cnt <= 0, go to RUN. An FT arriving in RUN abandons the partial pixel silently; OVF is not set.
  - EN&&!FT in RUN: cnt[i] <= cnt[i]+SPK[i], saturating at 2^CNT_WIDTH-1; t_cnt <= t_cnt+1.
  - EN&&!FT in IDLE: ignored.
  - EN low: hold all state.
- Done condition: EN && (FT ? 0 : t_cnt+1) == T.
  - The final counts include this cycle's SPK.
  - FSM returns to IDLE, except that done with FT and T==0 stays eligible for a new FT next cycle (state IDLE).
  - T==0: every EN&&FT cycle is a complete pixel.
- Packing at done: build WORDS words from the final counts.
  - Word k = {cnt[k*PER+PER-1], ..., cnt[k*PER]}; the lowest-index neuron sits in the LSBs.
  - Word 0 is pushed first.
- FIFO push is all-or-nothing:
  - If free space >= WORDS, all WORDS words are written in the done cycle.
  - Otherwise the whole pixel is dropped and OVF <= 1.
  - Free space is evaluated from occupancy at the start of the cycle. A same-cycle pop does not create space.
- FIFO pop: OUT_VALID && OUT_READY advances the head.
  - OUT_DATA = head word when OUT_VALID. OUT_DATA is held (don't-care content) when empty.
  - Simultaneous push and pop: occupancy = occ + WORDS - 1.
- Latency: done in cycle k gives OUT_VALID=1 and OUT_DATA=word0 in cycle k+1 (FIFO previously empty).
- Throughput: a full FIFO stalls only the output side. The input is never back-pressured; excess pixels are dropped and flagged.
- CLR (synchronous, highest priority after reset):
  - Empties the FIFO, clears counts and t_cnt, state IDLE, OVF 0.
  - Ignores same-cycle EN/FT and pop.
- BUSY = (state==RUN) || OUT_VALID.
- OVF is cleared only by CLR or reset.

Test Plan:
1. T=3, N_OUT=4, CNT_WIDTH=8. Drive EN 4 cycles, FT on first; SPK=4'b0001, 4'b0011, 4'b1001, 4'b0001; OUT_READY=1 -> cycle after 4th EN: OUT_DATA=16'h0104, then 16'h0100; OUT_VALID falls after 2 words.
2. T=0, EN&&FT for 3 consecutive cycles with SPK=4'b1111, OUT_READY=0 -> 6 words queued, each 16'h0101; OVF=0. A 4th pixel fits (8 words). A 5th pixel gives OVF=1, occupancy stays 8, first 8 words intact.
3. Saturation: T=31, CNT_WIDTH=4, SPK bit0 high every cycle for 32 timesteps -> cnt[0] reports 4'hF, no wrap.
4. EN gaps: T=2, EN pattern 1,0,0,1,0,1 with FT on first; SPK=4'b0100 on each EN -> one pixel, word0=16'h0000, word1=16'h0003; done on the 3rd EN.
5. Abandon/ignore: EN&&!FT while IDLE -> no push. FT mid-pixel at t_cnt=1 with T=3 -> only the restarted pixel emerges, after 4 EN cycles from the new FT.
6. RSTB asserted mid-accumulation with FIFO holding 2 words -> OUT_VALID, BUSY, OVF go 0 immediately. CLR with pending data and a same-cycle done -> FIFO empty next cycle, no push.

Source files
------------

// File: rtl/spike_collector_if.sv
// ---------------------------------------------------------------------------
// spike_collector_if
// Groups the spike collector's streaming signals.
//   Input side : EN (window strobe), FT (first timestep), SPK (spike vector)
//   Output side: OUT_DATA / OUT_VALID / OUT_READY word stream
// Modports:
//   slave  - the collector (consumes EN/FT/SPK, produces the word stream)
//   master - the environment (drives EN/FT/SPK, consumes the word stream)
// ---------------------------------------------------------------------------
interface spike_collector_if #(
    parameter int unsigned N_OUT    = 4,
    parameter int unsigned IO_WIDTH = 16
);
    logic                EN;
    logic                FT;
    logic [N_OUT-1:0]    SPK;
    logic [IO_WIDTH-1:0] OUT_DATA;
    logic                OUT_VALID;
    logic                OUT_READY;

    modport master (
        output EN, FT, SPK, OUT_READY,
        input  OUT_DATA, OUT_VALID
    );

    modport slave (
        input  EN, FT, SPK, OUT_READY,
        output OUT_DATA, OUT_VALID
    );
endinterface

// File: rtl/spike_collector.sv
// ---------------------------------------------------------------------------
// spike_collector
// Accumulates per-neuron spike counts over the T+1 timesteps of each output
// pixel, packs the finished counts into IO_WIDTH-bit words and queues them
// in a FIFO drained through a valid/ready port.
// Ports:
//   CLK   - clock
//   RSTB  - asynchronous active-low reset
//   T     - timesteps-1 per pixel, static while BUSY
//   CLR   - synchronous flush (FIFO, counts, OVF)
//   BUSY  - accumulation in progress or FIFO non-empty
//   OVF   - sticky: a finished pixel was dropped for lack of FIFO space
//   io    - EN/FT/SPK input strobes and OUT_DATA/OUT_VALID/OUT_READY stream
// ---------------------------------------------------------------------------
module spike_collector #(
    parameter int unsigned N_OUT     = 4,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned T_WIDTH   = 5,
    parameter int unsigned IO_WIDTH  = 16,
    parameter int unsigned DEPTH     = 8
) (
    input  logic               CLK,
    input  logic               RSTB,
    input  logic [T_WIDTH-1:0] T,
    input  logic               CLR,
    output logic               BUSY,
    output logic               OVF,
    spike_collector_if.slave   io
);
    localparam int unsigned WORDS = N_OUT * CNT_WIDTH / IO_WIDTH;
    localparam int unsigned PER   = IO_WIDTH / CNT_WIDTH;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] WORDS_L = (AW+1)'(WORDS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt     [N_OUT];
    logic [CNT_WIDTH-1:0]  w_cnt_nxt [N_OUT];
    logic [CNT_WIDTH:0]    w_sum     [N_OUT];
    logic [T_WIDTH-1:0]    r_tcnt, w_tcnt_nxt;
    logic                  w_done;

    logic [IO_WIDTH-1:0]   w_word [WORDS];
    logic [IO_WIDTH-1:0]   r_mem  [DEPTH];
    logic [AW-1:0]         r_rd, r_wr;
    logic [AW:0]           r_occ;
    logic                  w_fits, w_push, w_drop, w_pop;

    // ---------------- accumulator FSM ----------------
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state <= IDLE;
            r_tcnt  <= '0;
            for (int unsigned i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
            for (int unsigned i = 0; i < N_OUT; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_done      = 1'b0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            w_sum[i]     = {1'b0, r_cnt[i]} + (CNT_WIDTH+1)'(io.SPK[i]);
        end
        if (CLR) begin
            w_state_nxt = IDLE;
            w_tcnt_nxt  = '0;
            for (int unsigned i = 0; i < N_OUT; i++) w_cnt_nxt[i] = '0;
        end else if (io.EN) begin
            if (io.FT) begin
                // A new FT restarts the pixel even mid-accumulation.
                for (int unsigned i = 0; i < N_OUT; i++)
                    w_cnt_nxt[i] = CNT_WIDTH'(io.SPK[i]);
                w_tcnt_nxt  = '0;
                w_done      = (T == '0);
                w_state_nxt = w_done ? IDLE : RUN;
            end else if (r_state == RUN) begin
                for (int unsigned i = 0; i < N_OUT; i++)
                    w_cnt_nxt[i] = w_sum[i][CNT_WIDTH] ? '1 : w_sum[i][CNT_WIDTH-1:0];
                w_tcnt_nxt = r_tcnt + 1'b1;
                w_done     = (w_tcnt_nxt == T);
                if (w_done) w_state_nxt = IDLE;
            end
        end
    end

    // Lowest-index neuron of each group lands in the word's LSBs.
    always_comb begin
        for (int unsigned k = 0; k < WORDS; k++) begin
            w_word[k] = '0;
            for (int unsigned j = 0; j < PER; j++)
                w_word[k][j*CNT_WIDTH +: CNT_WIDTH] = w_cnt_nxt[k*PER + j];
        end
    end

    // ---------------- output FIFO ----------------
    // Space is judged on start-of-cycle occupancy; a same-cycle pop never helps.
    assign w_fits = (DEPTH_L - r_occ) >= WORDS_L;
    assign w_push = w_done && w_fits;
    assign w_drop = w_done && !w_fits;
    assign w_pop  = (r_occ != '0) && io.OUT_READY && !CLR;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd  <= '0;
            r_wr  <= '0;
            r_occ <= '0;
            OVF   <= 1'b0;
        end else if (CLR) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_occ <= '0;
            OVF   <= 1'b0;
        end else begin
            if (w_push) begin
                for (int unsigned k = 0; k < WORDS; k++)
                    r_mem[r_wr + AW'(k)] <= w_word[k];
                r_wr <= r_wr + AW'(WORDS);
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_occ <= r_occ + (w_push ? WORDS_L : '0) - (AW+1)'(w_pop);
            if (w_drop) OVF <= 1'b1;
        end
    end

    assign io.OUT_DATA  = r_mem[r_rd];
    assign io.OUT_VALID = (r_occ != '0);
    assign BUSY         = (r_state == RUN) || io.OUT_VALID;

endmodule

// File: tb/tb_spike_collector.sv
// ---------------------------------------------------------------------------
// tb_spike_collector
// Directed bench for spike_collector. A pixel-level model (counts per pixel,
// a word queue) is checked against the DUT every cycle; directed sequences
// add hand-computed literal expectations. A second instance with 4-bit
// counters covers saturation.
// ---------------------------------------------------------------------------
module tb_spike_collector;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RSTB;
    logic [4:0] T;
    logic       CLR;
    logic       BUSY, OVF;

    logic [4:0] T2;
    logic       CLR2;
    logic       BUSY2, OVF2;

    spike_collector_if #(.N_OUT(4), .IO_WIDTH(16)) io  ();
    spike_collector_if #(.N_OUT(4), .IO_WIDTH(16)) io2 ();

    spike_collector #(
        .N_OUT(4), .CNT_WIDTH(8), .T_WIDTH(5), .IO_WIDTH(16), .DEPTH(8)
    ) dut (
        .CLK(CLK), .RSTB(RSTB), .T(T), .CLR(CLR),
        .BUSY(BUSY), .OVF(OVF), .io(io)
    );

    spike_collector #(
        .N_OUT(4), .CNT_WIDTH(4), .T_WIDTH(5), .IO_WIDTH(16), .DEPTH(4)
    ) dut_sat (
        .CLK(CLK), .RSTB(RSTB), .T(T2), .CLR(CLR2),
        .BUSY(BUSY2), .OVF(OVF2), .io(io2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- pixel-level model of the main instance ----------------
    int          m_cnt [4];
    bit          m_in;
    int          m_steps;
    bit          m_ovf;
    logic [15:0] m_q [$];

    always @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            m_q.delete();
            m_in = 0; m_steps = 0; m_ovf = 0;
        end else if (CLR) begin
            m_q.delete();
            m_in = 0; m_steps = 0; m_ovf = 0;
        end else begin
            int size0;
            size0 = m_q.size();
            if (size0 > 0 && io.OUT_READY) void'(m_q.pop_front());
            if (io.EN) begin
                if (io.FT) begin
                    m_in = 1; m_steps = 1;
                    for (int i = 0; i < 4; i++) m_cnt[i] = int'(io.SPK[i]);
                end else if (m_in) begin
                    m_steps++;
                    for (int i = 0; i < 4; i++) begin
                        m_cnt[i] = m_cnt[i] + int'(io.SPK[i]);
                        if (m_cnt[i] > 255) m_cnt[i] = 255;
                    end
                end
                if (m_in && m_steps == int'(T) + 1) begin
                    m_in = 0;
                    if (8 - size0 >= 2) begin
                        m_q.push_back(16'((m_cnt[1] << 8) | m_cnt[0]));
                        m_q.push_back(16'((m_cnt[3] << 8) | m_cnt[2]));
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (!RSTB) begin
            check("rst_valid", 32'(io.OUT_VALID), 0);
            check("rst_busy",  32'(BUSY), 0);
            check("rst_ovf",   32'(OVF), 0);
            check("rst_data",  32'(io.OUT_DATA), 0);
        end else begin
            check("valid", 32'(io.OUT_VALID), 32'(m_q.size() != 0));
            if (m_q.size() != 0) check("data", 32'(io.OUT_DATA), 32'(m_q[0]));
            check("ovf",  32'(OVF),  32'(m_ovf));
            check("busy", 32'(BUSY), 32'(m_in || m_q.size() != 0));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic en, input logic ft, input logic [3:0] spk);
        io.EN = en; io.FT = ft; io.SPK = spk;
        @(posedge CLK); #1;
        io.EN = 1'b0; io.FT = 1'b0; io.SPK = '0;
    endtask

    initial begin
        int n;
        RSTB = 1'b0; T = '0; CLR = 1'b0;
        io.EN = 1'b0; io.FT = 1'b0; io.SPK = '0; io.OUT_READY = 1'b0;
        T2 = '0; CLR2 = 1'b0;
        io2.EN = 1'b0; io2.FT = 1'b0; io2.SPK = '0; io2.OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_valid", 32'(io.OUT_VALID), 0);
        check("reset_busy",  32'(BUSY), 0);
        check("reset_ovf",   32'(OVF), 0);
        check("reset_data",  32'(io.OUT_DATA), 0);
        RSTB = 1'b1;
        cyc(0, 0, 4'h0);

        // 1: basic pixel, T=3
        T = 5'd3; io.OUT_READY = 1'b1;
        cyc(1, 1, 4'b0001);
        cyc(1, 0, 4'b0011);
        cyc(1, 0, 4'b1001);
        check("t1_not_yet", 32'(io.OUT_VALID), 0);
        cyc(1, 0, 4'b0001);
        check("t1_valid", 32'(io.OUT_VALID), 1);
        check("t1_word0", 32'(io.OUT_DATA), 32'h0104);
        cyc(0, 0, 4'h0);
        check("t1_word1", 32'(io.OUT_DATA), 32'h0100);
        cyc(0, 0, 4'h0);
        check("t1_empty", 32'(io.OUT_VALID), 0);

        // 2: T=0 back-to-back pixels, fill and overflow
        T = 5'd0; io.OUT_READY = 1'b0;
        cyc(1, 1, 4'b1111);
        cyc(1, 1, 4'b1111);
        cyc(1, 1, 4'b1111);
        check("t2_ovf0", 32'(OVF), 0);
        check("t2_head", 32'(io.OUT_DATA), 32'h0101);
        cyc(1, 1, 4'b1111);
        check("t2_ovf_fit", 32'(OVF), 0);
        cyc(1, 1, 4'b0010);
        check("t2_ovf1", 32'(OVF), 1);
        io.OUT_READY = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!io.OUT_VALID) break;
            check("t2_drain", 32'(io.OUT_DATA), 32'h0101);
            n++;
            @(posedge CLK); #1;
        end
        check("t2_count", 32'(n), 8);
        check("t2_ovf_sticky", 32'(OVF), 1);
        CLR = 1'b1;
        cyc(0, 0, 4'h0);
        CLR = 1'b0;
        check("t2_clr_ovf", 32'(OVF), 0);

        // 4: EN gaps, T=2
        T = 5'd2; io.OUT_READY = 1'b1;
        cyc(1, 1, 4'b0100);
        cyc(0, 0, 4'b1111);
        cyc(0, 0, 4'b1111);
        cyc(1, 0, 4'b0100);
        cyc(0, 0, 4'b1111);
        check("t4_not_yet", 32'(io.OUT_VALID), 0);
        check("t4_busy", 32'(BUSY), 1);
        cyc(1, 0, 4'b0100);
        check("t4_valid", 32'(io.OUT_VALID), 1);
        check("t4_word0", 32'(io.OUT_DATA), 32'h0000);
        cyc(0, 0, 4'h0);
        check("t4_word1", 32'(io.OUT_DATA), 32'h0003);
        cyc(0, 0, 4'h0);
        check("t4_empty", 32'(io.OUT_VALID), 0);
        check("t4_idle", 32'(BUSY), 0);

        // 5: ignore in IDLE, abandon mid-pixel
        T = 5'd3;
        cyc(1, 0, 4'b1111);
        check("t5_ignored", 32'(io.OUT_VALID), 0);
        check("t5_idle", 32'(BUSY), 0);
        cyc(1, 1, 4'b0001);
        cyc(1, 0, 4'b0001);
        cyc(1, 1, 4'b0010);
        cyc(1, 0, 4'b0010);
        cyc(1, 0, 4'b0010);
        check("t5_not_yet", 32'(io.OUT_VALID), 0);
        cyc(1, 0, 4'b0010);
        check("t5_valid", 32'(io.OUT_VALID), 1);
        check("t5_word0", 32'(io.OUT_DATA), 32'h0400);
        cyc(0, 0, 4'h0);
        check("t5_word1", 32'(io.OUT_DATA), 32'h0000);
        cyc(0, 0, 4'h0);
        check("t5_empty", 32'(io.OUT_VALID), 0);

        // 3: saturation on the 4-bit-counter instance, T=31
        T2 = 5'd31; io2.OUT_READY = 1'b1;
        for (int i = 0; i < 32; i++) begin
            io2.EN  = 1'b1;
            io2.FT  = (i == 0);
            io2.SPK = {2'b00, (i < 10), 1'b1};
            @(posedge CLK); #1;
        end
        io2.EN = 1'b0; io2.FT = 1'b0; io2.SPK = '0;
        check("t3_valid", 32'(io2.OUT_VALID), 1);
        check("t3_word", 32'(io2.OUT_DATA), 32'h00AF);
        @(posedge CLK); #1;
        check("t3_empty", 32'(io2.OUT_VALID), 0);

        // 6: async reset mid-accumulation with FIFO holding 2 words
        T = 5'd0; io.OUT_READY = 1'b0;
        cyc(1, 1, 4'b1111);
        T = 5'd3;
        cyc(1, 1, 4'b0001);
        cyc(1, 0, 4'b0001);
        check("t6_pre_valid", 32'(io.OUT_VALID), 1);
        check("t6_pre_busy", 32'(BUSY), 1);
        #2 RSTB = 1'b0;
        #1;
        check("t6_rst_valid", 32'(io.OUT_VALID), 0);
        check("t6_rst_busy", 32'(BUSY), 0);
        check("t6_rst_ovf", 32'(OVF), 0);
        @(posedge CLK); #1;
        RSTB = 1'b1;
        cyc(0, 0, 4'h0);
        check("t6_post_busy", 32'(BUSY), 0);

        // 6b: CLR with pending data and a same-cycle done
        T = 5'd0;
        cyc(1, 1, 4'b1111);
        check("t6_clr_pre", 32'(io.OUT_VALID), 1);
        io.OUT_READY = 1'b1;
        CLR = 1'b1;
        cyc(1, 1, 4'b1111);
        CLR = 1'b0;
        check("t6_clr_valid", 32'(io.OUT_VALID), 0);
        check("t6_clr_busy", 32'(BUSY), 0);
        cyc(0, 0, 4'h0);
        check("t6_clr_nopush", 32'(io.OUT_VALID), 0);

        repeat (2) @(posedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
